// File: rtl/rx_ten_eight.sv
// UART receiver: start bit 0, 8 data bits LSB first, stop bit 1; mid-bit sampling at baud clocks per bit.
// Latency: about SYNC_STAGES+1+(baud>>1)+9*baud cycles from start edge to rx_valid; no backpressure, strobes are one-cycle pulses.
module rx_ten_eight #(
   parameter int BAUD_W      = 20,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [BAUD_W-1:0] baud,
   input  logic              rx_in,
   output logic [7:0]        rx_d,
   output logic              rx_valid,
   output logic              frame_err,
   output logic              rx_busy
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   rxs;
   logic                   rxs_q, rxs_d;
   logic [1:0]             state_q, state_d;
   logic [BAUD_W-1:0]      baud_l_q, baud_l_d;
   logic [BAUD_W-1:0]      cnt_q, cnt_d;
   logic [2:0]             idx_q, idx_d;
   logic [7:0]             shift_q, shift_d;
   logic [7:0]             rx_d_q, rx_d_d;
   logic                   rx_valid_q, rx_valid_d;
   logic                   frame_err_q, frame_err_d;
   logic [BAUD_W-1:0]      half_m1;
   logic [BAUD_W-1:0]      full_m1;

   assign rxs     = sync_q[SYNC_STAGES-1];
   assign half_m1 = (baud_l_q >> 1) - BAUD_W'(1);
   assign full_m1 = baud_l_q - BAUD_W'(1);

   always_comb begin
      sync_d      = {sync_q[SYNC_STAGES-2:0], rx_in};
      rxs_d       = rxs;
      state_d     = state_q;
      baud_l_d    = baud_l_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      shift_d     = shift_q;
      rx_d_d      = rx_d_q;
      rx_valid_d  = 1'b0;
      frame_err_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // Requiring a high-to-low transition keeps a held-low line (break) from retriggering.
            if (en && rxs_q && !rxs) begin
               baud_l_d = baud;
               cnt_d    = '0;
               state_d  = ST_START;
            end
         end
         ST_START: begin
            if (cnt_q == half_m1) begin
               cnt_d = '0;
               if (!rxs) begin
                  idx_d   = 3'd0;
                  state_d = ST_DATA;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               cnt_d = cnt_q + BAUD_W'(1);
            end
         end
         ST_DATA: begin
            if (cnt_q == full_m1) begin
               shift_d[idx_q] = rxs;
               cnt_d          = '0;
               if (idx_q == 3'd7) begin
                  state_d = ST_STOP;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + BAUD_W'(1);
            end
         end
         ST_STOP: begin
            if (cnt_q == full_m1) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
               if (rxs) begin
                  rx_d_d     = shift_q;
                  rx_valid_d = 1'b1;
               end else begin
                  frame_err_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + BAUD_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (!en) begin
         state_d     = ST_IDLE;
         cnt_d       = '0;
         rx_d_d      = rx_d_q;
         rx_valid_d  = 1'b0;
         frame_err_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q      <= '1;
         rxs_q       <= 1'b1;
         state_q     <= ST_IDLE;
         baud_l_q    <= '0;
         cnt_q       <= '0;
         idx_q       <= 3'd0;
         shift_q     <= 8'h00;
         rx_d_q      <= 8'h00;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         sync_q      <= sync_d;
         rxs_q       <= rxs_d;
         state_q     <= state_d;
         baud_l_q    <= baud_l_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         shift_q     <= shift_d;
         rx_d_q      <= rx_d_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign rx_d      = rx_d_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;
   assign rx_busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rx_ten_eight.sv
// Bench for rx_ten_eight: a serial driver pushes expected strobes into a queue, a negedge monitor pops and compares.
module tb_rx_ten_eight;

   localparam int BAUD_W = 20;
   localparam int SYNC   = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              en = 1'b1;
   logic [BAUD_W-1:0] baud = 20'd8;
   logic              rx_in = 1'b1;
   logic [7:0]        rx_d;
   logic              rx_valid;
   logic              frame_err;
   logic              rx_busy;

   typedef struct {
      bit         ferr;
      logic [7:0] dat;
      int         lo;
      int         hi;
   } exp_t;

   exp_t       exp_q[$];
   int         errors = 0;
   int         checks = 0;
   int         cyc = 0;
   logic [7:0] last_good = 8'h00;
   bit         prev_strobe = 1'b0;

   rx_ten_eight #(.BAUD_W(BAUD_W), .SYNC_STAGES(SYNC)) dut (
      .clk(clk), .rst(rst), .en(en), .baud(baud), .rx_in(rx_in),
      .rx_d(rx_d), .rx_valid(rx_valid), .frame_err(frame_err), .rx_busy(rx_busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, req);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Acts as the transmit path: caller is aligned at posedge+1.
   task automatic send_frame(input logic [7:0] dat, input bit stop, input int bpb);
      exp_t e;
      rx_in  = 1'b0;
      e.ferr = !stop;
      e.dat  = stop ? dat : last_good;
      e.lo   = cyc + SYNC + 1 + (bpb >> 1) + 9 * bpb - 1;
      e.hi   = e.lo + 2;
      exp_q.push_back(e);
      if (stop) last_good = dat;
      for (int i = 0; i < 8; i++) begin
         repeat (bpb) @(posedge clk);
         #1 rx_in = dat[i];
      end
      repeat (bpb) @(posedge clk);
      #1 rx_in = stop;
      repeat (bpb) @(posedge clk);
      #1 rx_in = 1'b1;
   endtask

   task automatic send_partial(input logic [7:0] dat, input int nbits, input int bpb);
      rx_in = 1'b0;
      for (int i = 0; i < nbits; i++) begin
         repeat (bpb) @(posedge clk);
         #1 rx_in = dat[i];
      end
      repeat (bpb) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (rx_valid || frame_err) begin
         chk("strobe_exclusive", {31'd0, rx_valid & frame_err}, 32'd0);
         chk("strobe_not_consecutive", {31'd0, prev_strobe}, 32'd0);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe: rx_valid=%0b frame_err=%0b rx_d=%0h, expected none", rx_valid, frame_err, rx_d);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("strobe_kind_frame_err", {31'd0, frame_err}, {31'd0, e.ferr});
            chk("rx_d_value", {24'd0, rx_d}, {24'd0, e.dat});
            checks++;
            if (cyc < e.lo || cyc > e.hi) begin
               errors++;
               $display("FAIL strobe_latency: at cycle %0d, expected %0d..%0d", cyc, e.lo, e.hi);
            end
         end
      end
      prev_strobe = rx_valid || frame_err;
   end

   initial begin
      int n;
      idle(4);
      chk("reset_rx_d", {24'd0, rx_d}, 32'd0);
      chk("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
      chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
      chk("reset_rx_busy", {31'd0, rx_busy}, 32'd0);
      rst = 1'b0;
      idle(10);

      // Nominal 0xA5; baud input changes mid-frame and must be ignored.
      baud = 20'd8;
      fork
         send_frame(8'hA5, 1'b1, 8);
         begin
            idle(6);
            baud = 20'd20;
         end
      join
      baud = 20'd8;
      idle(20);

      send_frame(8'h00, 1'b1, 8);
      send_frame(8'hFF, 1'b1, 8);
      idle(20);

      // Bad stop bit; line stays low until the next start so a gap is needed.
      send_frame(8'h3C, 1'b0, 8);
      idle(16);
      send_frame(8'h5A, 1'b1, 8);
      idle(20);

      baud = 20'd16;
      idle(4);
      rx_in = 1'b0;
      idle(3);
      rx_in = 1'b1;
      n = 0;
      while (!rx_busy && n < 10) begin
         idle(1);
         n++;
      end
      chk("glitch_busy_rise", {31'd0, rx_busy}, 32'd1);
      n = 0;
      while (rx_busy && n < 20) begin
         idle(1);
         n++;
      end
      checks++;
      if (n > 8 || rx_busy) begin
         errors++;
         $display("FAIL glitch_busy_fall: busy for %0d cycles, expected at most 8", n);
      end
      idle(20);

      baud = 20'd8;
      send_partial(8'hC3, 4, 8);
      chk("abort_en_busy_before", {31'd0, rx_busy}, 32'd1);
      en = 1'b0;
      idle(1);
      chk("abort_en_busy_after", {31'd0, rx_busy}, 32'd0);
      chk("abort_en_rx_d_held", {24'd0, rx_d}, 32'h5A);
      rx_in = 1'b1;
      idle(20);
      en = 1'b1;
      idle(10);

      send_partial(8'hC3, 4, 8);
      rst   = 1'b1;
      rx_in = 1'b1;
      idle(1);
      chk("abort_rst_rx_d", {24'd0, rx_d}, 32'd0);
      chk("abort_rst_rx_valid", {31'd0, rx_valid}, 32'd0);
      chk("abort_rst_frame_err", {31'd0, frame_err}, 32'd0);
      chk("abort_rst_rx_busy", {31'd0, rx_busy}, 32'd0);
      rst       = 1'b0;
      last_good = 8'h00;
      idle(20);

      baud = 20'd1000;
      send_frame(8'h00, 1'b1, 1000);
      send_frame(8'h55, 1'b1, 1000);
      send_frame(8'hAA, 1'b1, 1000);
      send_frame(8'hFF, 1'b1, 1000);

      for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge clk);
      #1;
      chk("scoreboard_drained", exp_q.size(), 32'd0);
      idle(20);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
